pulse_stretch_led: RTL and testbench

- Output-side counterpart of the button conditioning path.
- Converts single-cycle event pulses, such as debounced key presses or FSM events, into human-visible LED flashes of guaranteed minimum on-time and off-gap.
- Events arriving while a flash is in progress are queued in a saturating counter, so each accepted event yields exactly one distinct flash.
- Sits between control logic and board LED pins.

---
 rtl/pulse_stretch_led.sv | 106 ++++++++++
 tb/tb_pulse_stretch_led.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_led.sv
// Stretches single-cycle event strobes into LED flashes with a guaranteed on-time and off-gap.
// Events that arrive during a flash are queued in a saturating counter and replayed back-to-back.
module pulse_stretch_led #(
  parameter int ON_CYCLES  = 5000000,
  parameter int OFF_CYCLES = 5000000,
  parameter int TIMER_W    = 23,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W:0]     PEND_MAX = {1'b0, {CNT_W{1'b1}}};

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               led_q, led_d;
  logic               avail;
  logic               start;
  logic [CNT_W:0]     pend_sum;
  logic               sat;

  // A flash may begin from IDLE at once, or straight out of the last GAP cycle.
  always_comb begin
    avail = (pend_q != '0) | pulse_in;
    start = avail & ((state_q == IDLE) |
                     ((state_q == GAP) && (timer_q == OFF_LAST)));
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (start) begin
          state_d = ON;
        end
      end
      ON: begin
        if (timer_q == ON_LAST) begin
          state_d = GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      GAP: begin
        if (timer_q == OFF_LAST) begin
          state_d = start ? ON : IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    led_d = (state_d == ON);
  end

  // Extra bit holds the carry so saturation can be detected before truncation.
  always_comb begin
    pend_sum = {1'b0, pend_q}
             + {{CNT_W{1'b0}}, pulse_in}
             - {{CNT_W{1'b0}}, start};
    sat      = (pend_sum > PEND_MAX);
    pend_d   = sat ? pend_q : pend_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
    end
  end

  assign led      = led_q;
  assign pending  = pend_q;
  assign overflow = sat;
  assign busy     = (state_q != IDLE) | (pend_q != '0);

endmodule

// File: tb/tb_pulse_stretch_led.sv
// Directed bench for pulse_stretch_led with ON=4, OFF=3, CNT_W=2.
// Rows hold constant stimulus/expectations for a run of cycles.
module tb_pulse_stretch_led;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse_in = 1'b0;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int row_idx = 0;

  typedef struct {
    int         n;
    logic       rst;
    logic       pulse;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } row_t;

  row_t rows[$];

  pulse_stretch_led #(
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .TIMER_W   (3),
    .CNT_W     (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_in),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s row=%0d t=%0t: got %0d want %0d", name, row_idx, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic p, input logic l_e, input logic b_e,
                     input logic [1:0] pd_e, input logic o_e);
    @(negedge clk);
    rst_n    = ~r;
    pulse_in = p;
    #1;
    chk("led", int'(led), int'(l_e));
    chk("busy", int'(busy), int'(b_e));
    chk("pending", int'(pending), int'(pd_e));
    chk("overflow", int'(overflow), int'(o_e));
  endtask

  function automatic void add(input int n, input logic r, input logic p, input logic l,
                              input logic b, input logic [1:0] pd, input logic o);
    row_t x;
    x.n = n; x.rst = r; x.pulse = p; x.led = l; x.busy = b; x.pend = pd; x.ovf = o;
    rows.push_back(x);
  endfunction

  function automatic void add_prefix();
    add(2, 1, 0, 0, 0, 0, 0);
    add(10, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    int found;
    int waited;

    // Single pulse at cycle 10
    add_prefix();
    add(1, 0, 1, 0, 0, 0, 0);
    add(4, 0, 0, 1, 1, 0, 0);
    add(3, 0, 0, 0, 1, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);

    // Pulses at 10, 12, 13
    add_prefix();
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 1, 1, 1, 0, 0);
    add(1, 0, 1, 1, 1, 1, 0);
    add(1, 0, 0, 1, 1, 2, 0);
    add(3, 0, 0, 0, 1, 2, 0);
    add(4, 0, 0, 1, 1, 1, 0);
    add(3, 0, 0, 0, 1, 1, 0);
    add(4, 0, 0, 1, 1, 0, 0);
    add(3, 0, 0, 0, 1, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);

    // Six consecutive pulses: saturation and overflow on 14, 15
    add_prefix();
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0, 0);
    add(1, 0, 1, 1, 1, 1, 0);
    add(1, 0, 1, 1, 1, 2, 0);
    add(1, 0, 1, 1, 1, 3, 1);
    add(1, 0, 1, 0, 1, 3, 1);
    add(2, 0, 0, 0, 1, 3, 0);
    add(4, 0, 0, 1, 1, 2, 0);
    add(3, 0, 0, 0, 1, 2, 0);
    add(4, 0, 0, 1, 1, 1, 0);
    add(3, 0, 0, 0, 1, 1, 0);
    add(4, 0, 0, 1, 1, 0, 0);
    add(3, 0, 0, 0, 1, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);

    // Pulse on the last GAP cycle with nothing queued: no IDLE gap
    add_prefix();
    add(1, 0, 1, 0, 0, 0, 0);
    add(4, 0, 0, 1, 1, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0);
    add(4, 0, 0, 1, 1, 0, 0);
    add(3, 0, 0, 0, 1, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);

    // pending at max with a pulse on the GAP->ON cycle: net zero, no overflow
    add_prefix();
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0, 0);
    add(1, 0, 1, 1, 1, 1, 0);
    add(1, 0, 1, 1, 1, 2, 0);
    add(1, 0, 1, 1, 1, 3, 1);
    add(1, 0, 1, 0, 1, 3, 1);
    add(1, 0, 0, 0, 1, 3, 0);
    add(1, 0, 1, 0, 1, 3, 0);
    add(4, 0, 0, 1, 1, 3, 0);
    add(3, 0, 0, 0, 1, 3, 0);
    add(4, 0, 0, 1, 1, 2, 0);
    add(3, 0, 0, 0, 1, 2, 0);
    add(4, 0, 0, 1, 1, 1, 0);
    add(3, 0, 0, 0, 1, 1, 0);
    add(4, 0, 0, 1, 1, 0, 0);
    add(3, 0, 0, 0, 1, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < rows.size(); i++) begin
      row_idx = i;
      for (int c = 0; c < rows[i].n; c++) begin
        cyc(rows[i].rst, rows[i].pulse, rows[i].led, rows[i].busy, rows[i].pend, rows[i].ovf);
      end
    end

    // Reset mid-flash with two events queued
    row_idx = -1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      cyc(0, 0, 0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0, 0, 0);
    found  = 0;
    waited = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pulse_in = 1'b0;
      #1;
      if (led) begin
        found = 1;
        break;
      end
      waited++;
    end
    chk("led_after_new_pulse", found, 1);
    chk("new_pulse_latency", waited, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
